data_mem_param: RTL and testbench
=================================

DATA_MEM_PARAM -- requirements
Module: data_mem_param

Interface
Parameters:
REQ-001 SHALL provide parameter DEPTH, default 1024: data words stored; power of two, range 16..16384.
REQ-002 SHALL provide parameter BASE_ADDR, default 32'h0000_0000: byte address of word 0; word-aligned.
REQ-003 SHALL provide parameter LED_ADDR, default 32'h0000_2000: byte address of the LED register; word-aligned; outside the data window.
REQ-004 SHALL provide parameter LED_WIDTH, default 8: width of the led output, 1..32.

Ports:
REQ-005 SHALL have: clk  input  1  sole clock; all state changes on its rising edge.
REQ-006 SHALL have: reset  input  1  synchronous, active-high reset.
REQ-007 SHALL have: addr  input  32  byte address of the access.
REQ-008 SHALL have: write_data  input  32  store data, right-aligned.
REQ-009 SHALL have: memwrite  input  1  store request.
REQ-010 SHALL have: memread  input  1  load request.
REQ-011 SHALL have: sign_mask  input  4  [3] sign-extend loads; [2:0] size: 3'b001 byte, 3'b011 halfword, 3'b111 word.
REQ-012 SHALL have: read_data  output  32  registered load result.
REQ-013 SHALL have: clk_stall  output  1  high while an access is in flight; core holds its inputs.
REQ-014 SHALL have: led  output  LED_WIDTH  low bits of the LED register.
REQ-015 SHALL have: err  output  1  sticky: out-of-range or misaligned access seen.

Function
REQ-016 SHALL use FSM states IDLE, LOAD, RMW_READ, RMW_WRITE; state register is reset to IDLE.
REQ-017 SHALL accept requests only in IDLE; on acceptance, latch addr, write_data and sign_mask into buffers that stay stable until return to IDLE.
REQ-018 SHALL treat memwrite and memread both high as a store; the read request is ignored.
REQ-019 SHALL handle a load: IDLE->LOAD, clk_stall=1 for exactly 1 cycle; read_data updates on the LOAD->IDLE edge.
REQ-020 SHALL handle a store: IDLE->RMW_READ->RMW_WRITE->IDLE, clk_stall=1 for exactly 2 cycles; array written on the RMW_WRITE edge.
REQ-021 SHALL drive clk_stall combinationally high in the request cycle when the FSM is IDLE and a request is present, so the core stalls the same cycle.
REQ-022 SHALL form the word index as (addr-BASE_ADDR)>>2; in range iff addr>=BASE_ADDR and index<DEPTH.
REQ-023 SHALL merge stores: byte writes lane addr[1:0]; halfword writes lanes {addr[1],0} and {addr[1],1}; word writes all four lanes; other lanes keep their old value.
REQ-024 SHALL extract loads by lane as for stores: zero-extend when sign_mask[3]=0, else sign-extend from bit 7 (byte) or bit 15 (halfword); word loads are unaffected by sign_mask[3].
REQ-025 SHALL treat a halfword with addr[0]=1 or a word with addr[1:0]!=0 as misaligned: set err, ignore the low offset bits, and complete with normal timing.
REQ-026 SHALL complete an out-of-range access (not LED_ADDR) with normal timing: no array write, a load returns 32'h0, err set.
REQ-027 SHALL write write_data to the 32-bit LED register on a store to LED_ADDR in RMW_WRITE, regardless of size; led = led_reg[LED_WIDTH-1:0].
REQ-028 SHALL return the full 32-bit LED register, size-extracted per REQ-024, on a load from LED_ADDR.
REQ-029 SHALL hold read_data between loads; stores and stalls leave it unchanged.
REQ-030 SHALL use an undefined sign_mask[2:0] encoding as word size and set err.
REQ-031 SHALL give a load immediately after a store to the same word the stored data (no stale read).

Reset
REQ-032 SHALL, on reset high at a clock edge: state=IDLE, clk_stall=0, read_data=0, led_reg=0, err=0, buffers cleared.
REQ-033 SHALL let reset dominate requests in the same cycle; reset in RMW_READ or RMW_WRITE aborts the store with the array unmodified on that edge.
REQ-034 SHALL NOT clear array contents on reset; contents are undefined until written.

Verification
REQ-035 SHALL cover: store word 32'hDEADBEEF @0x10, then load word @0x10 -> 2 stall cycles, then 1 stall cycle, read_data=32'hDEADBEEF.
REQ-036 SHALL cover: store byte 8'h80 @0x13 over 32'h11223344, then signed byte load @0x13 -> 32'hFFFFFF80; unsigned word load @0x10 -> 32'h80223344.
REQ-037 SHALL cover: signed halfword load @0x12 of 32'h8001_0000 -> 32'hFFFF8001; unsigned -> 32'h00008001.
REQ-038 SHALL cover: store 32'hA5 to LED_ADDR -> led=8'hA5 after the RMW_WRITE edge; load @BASE_ADDR+4*DEPTH -> 32'h0, err=1 held until reset.
REQ-039 SHALL cover: reset asserted in RMW_WRITE of a store of 32'h0 over 32'h12345678 -> next cycle clk_stall=0, IDLE, later load reads 32'h12345678.
REQ-040 SHALL cover: memread and memwrite both high @0x20 with data 32'h5 -> store timing (2 stalls), read_data unchanged, later load returns 32'h5.

Source files
------------

// File: rtl/data_mem_param.sv
// data_mem_param
// Word-organised data memory for a small core, with byte/halfword/word
// loads and stores, one memory-mapped LED register and a sticky error flag.
// Loads take one stall cycle and stores two, because each store is a
// read-modify-write of a whole 32-bit word.
//
// Ports
//   clk        : sole clock; every state change happens on its rising edge
//   reset      : synchronous, active-high reset
//   addr       : byte address of the access
//   write_data : store data, right-aligned
//   memwrite   : store request (wins over memread when both are high)
//   memread    : load request
//   sign_mask  : [3] sign-extend loads, [2:0] size 001 byte / 011 half / 111 word
//   read_data  : registered load result, held between loads
//   clk_stall  : high while an access is in flight; the core holds its inputs
//   led        : low LED_WIDTH bits of the LED register
//   err        : sticky flag for out-of-range, misaligned or bad-size accesses
module data_mem_param #(
   parameter int          DEPTH     = 1024,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter logic [31:0] LED_ADDR  = 32'h0000_2000,
   parameter int          LED_WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [31:0]          addr,
   input  logic [31:0]          write_data,
   input  logic                 memwrite,
   input  logic                 memread,
   input  logic [3:0]           sign_mask,
   output logic [31:0]          read_data,
   output logic                 clk_stall,
   output logic [LED_WIDTH-1:0] led,
   output logic                 err
);

   localparam int AW = $clog2(DEPTH);

   typedef enum logic [1:0] {IDLE, LOAD, RMW_READ, RMW_WRITE} state_t;

   state_t        state_reg, state_next;
   logic [31:0]   addr_buf_reg, wdata_buf_reg;
   logic [3:0]    mask_buf_reg;
   logic [31:0]   led_reg;
   logic          err_reg;
   logic [31:0]   read_data_reg;
   logic [31:0]   mem [0:DEPTH-1];
   logic [31:0]   mem_rd_reg;

   // Address decode, shared by the incoming request and the buffered one.
   logic [31:0]   in_off, buf_off;
   logic          in_window, buf_window, in_is_led, buf_is_led;
   logic          in_bad_size, in_misaligned, accept_bad;
   logic [AW-1:0] rd_idx, buf_idx;

   logic          accept;
   logic          is_byte, is_half, sign_ext;
   logic [3:0]    lane_en;
   logic [31:0]   wr_lanes, merged;
   logic [31:0]   src_word, shifted_word, load_val;
   logic [15:0]   half_val;

   assign accept = (state_reg == IDLE) && (memwrite || memread);

   // Stall is raised combinationally in the request cycle so the core freezes
   // immediately, and held through RMW_READ so a store stalls two cycles.
   assign clk_stall = accept || (state_reg == RMW_READ);

   assign in_off     = addr - BASE_ADDR;
   assign buf_off    = addr_buf_reg - BASE_ADDR;
   assign in_window  = (addr >= BASE_ADDR) && (in_off[31:2] < 30'(DEPTH));
   assign buf_window = (addr_buf_reg >= BASE_ADDR) && (buf_off[31:2] < 30'(DEPTH));
   assign in_is_led  = (addr[31:2] == LED_ADDR[31:2]) && !in_window;
   assign buf_is_led = (addr_buf_reg[31:2] == LED_ADDR[31:2]) && !buf_window;

   assign in_bad_size   = (sign_mask[2:0] != 3'b001) && (sign_mask[2:0] != 3'b011)
                          && (sign_mask[2:0] != 3'b111);
   // An undefined size behaves as a word, so it is misaligned like one.
   assign in_misaligned = (sign_mask[2:0] == 3'b011) ? addr[0] :
                          (sign_mask[2:0] == 3'b001) ? 1'b0 : (addr[1:0] != 2'b00);
   assign accept_bad    = in_bad_size || in_misaligned || (!in_window && !in_is_led);

   // The array is read every cycle: in IDLE from the live address so a load's
   // word is ready during LOAD, otherwise from the buffer for the RMW merge.
   assign rd_idx  = (state_reg == IDLE) ? in_off[AW+1:2] : buf_off[AW+1:2];
   assign buf_idx = buf_off[AW+1:2];

   assign is_byte  = (mask_buf_reg[2:0] == 3'b001);
   assign is_half  = (mask_buf_reg[2:0] == 3'b011);
   assign sign_ext = mask_buf_reg[3];

   // Replicate store data across lanes, then pick lanes by size and offset.
   assign wr_lanes = is_byte ? {4{wdata_buf_reg[7:0]}} :
                     is_half ? {2{wdata_buf_reg[15:0]}} : wdata_buf_reg;

   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_lane
         localparam logic [1:0] LANE = 2'(gi);
         assign lane_en[gi] = is_byte ? (addr_buf_reg[1:0] == LANE) :
                              is_half ? (addr_buf_reg[1] == LANE[1]) : 1'b1;
         assign merged[8*gi +: 8] = lane_en[gi] ? wr_lanes[8*gi +: 8]
                                                : mem_rd_reg[8*gi +: 8];
      end
   endgenerate

   // Load path: choose the source word, then extract and extend by size.
   assign src_word     = buf_window ? mem_rd_reg : (buf_is_led ? led_reg : 32'h0);
   assign shifted_word = src_word >> {addr_buf_reg[1:0], 3'b000};
   assign half_val     = addr_buf_reg[1] ? src_word[31:16] : src_word[15:0];
   assign load_val     = is_byte ? {{24{sign_ext & shifted_word[7]}}, shifted_word[7:0]} :
                         is_half ? {{16{sign_ext & half_val[15]}}, half_val} : src_word;

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: begin
            if (memwrite)     state_next = RMW_READ;
            else if (memread) state_next = LOAD;
         end
         LOAD:      state_next = IDLE;
         RMW_READ:  state_next = RMW_WRITE;
         RMW_WRITE: state_next = IDLE;
         default:   state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg     <= IDLE;
         addr_buf_reg  <= '0;
         wdata_buf_reg <= '0;
         mask_buf_reg  <= '0;
         led_reg       <= '0;
         err_reg       <= 1'b0;
         read_data_reg <= '0;
      end else begin
         state_reg <= state_next;
         if (accept) begin
            addr_buf_reg  <= addr;
            wdata_buf_reg <= write_data;
            mask_buf_reg  <= sign_mask;
            if (accept_bad) err_reg <= 1'b1;
         end
         if (state_reg == LOAD) read_data_reg <= load_val;
         // The LED register takes the full word whatever the access size.
         if (state_reg == RMW_WRITE && buf_is_led) led_reg <= wdata_buf_reg;
      end
   end

   // Array kept free of reset so it maps onto block RAM; reset still blocks
   // the write so an aborted store leaves memory untouched.
   always_ff @(posedge clk) begin
      mem_rd_reg <= mem[rd_idx];
      if (state_reg == RMW_WRITE && buf_window && !reset) mem[buf_idx] <= merged;
   end

   assign read_data = read_data_reg;
   assign led       = led_reg[LED_WIDTH-1:0];
   assign err       = err_reg;

endmodule

// File: tb/tb_data_mem_param.sv
// Scoreboard bench for data_mem_param: the driver pushes the expected load
// result when it issues a load; a monitor spots accepted loads on the ports
// and compares read_data once the result is due.
module tb_data_mem_param;

   localparam logic [3:0] M_B  = 4'b0001;
   localparam logic [3:0] M_SB = 4'b1001;
   localparam logic [3:0] M_H  = 4'b0011;
   localparam logic [3:0] M_SH = 4'b1011;
   localparam logic [3:0] M_W  = 4'b0111;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] addr = '0;
   logic [31:0] write_data = '0;
   logic        memwrite = 1'b0;
   logic        memread = 1'b0;
   logic [3:0]  sign_mask = M_W;
   logic [31:0] read_data;
   logic        clk_stall;
   logic [7:0]  led;
   logic        err;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] exp_q[$];
   string       name_q[$];
   logic [31:0] last_load = 32'h0;

   data_mem_param dut (
      .clk(clk), .reset(reset), .addr(addr), .write_data(write_data),
      .memwrite(memwrite), .memread(memread), .sign_mask(sign_mask),
      .read_data(read_data), .clk_stall(clk_stall), .led(led), .err(err)
   );

   always #5 clk = ~clk;

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end else begin
         $display("ok   %s: %h", name, act);
      end
   endtask

   // Present a request and hold it while clk_stall is high, like the core.
   task automatic access(input logic we, input logic re, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] m, output int stalls);
      logic s;
      bit   done;
      addr = a; write_data = d; sign_mask = m; memwrite = we; memread = re;
      stalls = 0;
      done = 0;
      for (int i = 0; i < 10 && !done; i++) begin
         @(negedge clk);
         s = clk_stall;
         if (s) stalls++;
         @(posedge clk);
         #1;
         if (!s) done = 1;
      end
      memwrite = 1'b0;
      memread  = 1'b0;
      if (!done) begin
         checks++;
         errors++;
         $display("FAIL access_timeout: clk_stall still high after 10 cycles at %h", a);
      end
   endtask

   task automatic do_store(input string name, input logic [31:0] a,
                           input logic [31:0] d, input logic [3:0] m);
      int st;
      access(1'b1, 1'b0, a, d, m, st);
      check32({name, "_stalls"}, 32'(st), 32'd2);
      check32({name, "_rd_held"}, read_data, last_load);
   endtask

   task automatic do_load(input string name, input logic [31:0] a,
                          input logic [3:0] m, input logic [31:0] exp);
      int st;
      exp_q.push_back(exp);
      name_q.push_back(name);
      access(1'b0, 1'b1, a, 32'h0, m, st);
      check32({name, "_stalls"}, 32'(st), 32'd1);
      last_load = exp;
   endtask

   task automatic pulse_reset();
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      last_load = 32'h0;
   endtask

   // Monitor: an accepted load is a stalled cycle with memread alone; its
   // result is in read_data after the second following rising edge.
   initial begin
      logic [31:0] e;
      string       n;
      forever begin
         @(negedge clk);
         if (clk_stall && memread && !memwrite && !reset) begin
            @(posedge clk);
            @(posedge clk);
            #1;
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_load: read_data %h, expected no load result", read_data);
            end else begin
               e = exp_q.pop_front();
               n = name_q.pop_front();
               check32(n, read_data, e);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int st;
      repeat (3) @(posedge clk);
      #1;
      check32("reset_read_data", read_data, 32'h0);
      check32("reset_led", {24'h0, led}, 32'h0);
      check32("reset_err", {31'h0, err}, 32'h0);
      check32("reset_stall", {31'h0, clk_stall}, 32'h0);
      reset = 1'b0;
      @(posedge clk);
      #1;

      // Word store then load.
      do_store("st_deadbeef", 32'h10, 32'hDEADBEEF, M_W);
      do_load("ld_deadbeef", 32'h10, M_W, 32'hDEADBEEF);

      // Byte merge into an existing word.
      do_store("st_11223344", 32'h10, 32'h11223344, M_W);
      do_store("st_byte80", 32'h13, 32'h00000080, M_B);
      do_load("ld_sbyte13", 32'h13, M_SB, 32'hFFFFFF80);
      do_load("ld_word10_merged", 32'h10, M_W, 32'h80223344);

      // Halfword extraction, signed and unsigned.
      do_store("st_80010000", 32'h10, 32'h80010000, M_W);
      do_load("ld_shalf12", 32'h12, M_SH, 32'hFFFF8001);
      do_load("ld_uhalf12", 32'h12, M_H, 32'h00008001);
      check32("err_clean", {31'h0, err}, 32'h0);

      // LED register.
      do_store("st_led", 32'h2000, 32'h000000A5, M_W);
      check32("led_value", {24'h0, led}, 32'h000000A5);
      do_load("ld_led_word", 32'h2000, M_W, 32'h000000A5);
      do_load("ld_led_sbyte", 32'h2000, M_SB, 32'hFFFFFFA5);
      check32("err_after_led", {31'h0, err}, 32'h0);

      // Out-of-range: store must not alias onto word 0, load returns 0.
      do_store("st_word0", 32'h0, 32'hCAFEF00D, M_W);
      do_store("st_oor", 32'h1000, 32'h00000099, M_W);
      check32("err_after_oor_store", {31'h0, err}, 32'h1);
      do_load("ld_word0_intact", 32'h0, M_W, 32'hCAFEF00D);
      do_load("ld_oor", 32'h1000, M_W, 32'h0);
      check32("err_sticky", {31'h0, err}, 32'h1);

      // Reset in RMW_WRITE aborts the store.
      do_store("st_12345678", 32'h30, 32'h12345678, M_W);
      addr = 32'h30; write_data = 32'h0; sign_mask = M_W; memwrite = 1'b1;
      @(negedge clk);
      @(posedge clk);
      #1;
      @(negedge clk);
      @(posedge clk);
      #1;
      reset = 1'b1;
      memwrite = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b0;
      last_load = 32'h0;
      check32("abort_stall", {31'h0, clk_stall}, 32'h0);
      check32("abort_err_cleared", {31'h0, err}, 32'h0);
      check32("abort_read_data", read_data, 32'h0);
      check32("abort_led", {24'h0, led}, 32'h0);
      do_load("ld_after_abort", 32'h30, M_W, 32'h12345678);

      // memread and memwrite together act as a store.
      access(1'b1, 1'b1, 32'h20, 32'h5, M_W, st);
      check32("both_stalls", 32'(st), 32'd2);
      check32("both_rd_held", read_data, last_load);
      do_load("ld_both", 32'h20, M_W, 32'h00000005);

      // Halfword store into upper lanes, unsigned byte load.
      do_store("st_half_beef", 32'h22, 32'h0000BEEF, M_H);
      do_load("ld_ubyte23", 32'h23, M_B, 32'h000000BE);
      do_load("ld_word20_half", 32'h20, M_W, 32'hBEEF0005);
      check32("err_still_clear", {31'h0, err}, 32'h0);

      // Misaligned halfword load ignores addr[0] and flags err.
      do_load("ld_misaligned_half", 32'h13, M_SH, 32'hFFFF8001);
      check32("err_misaligned", {31'h0, err}, 32'h1);
      pulse_reset();
      check32("err_after_reset", {31'h0, err}, 32'h0);

      // Undefined size acts as word and flags err.
      do_load("ld_bad_size", 32'h10, 4'b0010, 32'h80010000);
      check32("err_bad_size", {31'h0, err}, 32'h1);

      // Misaligned word store writes the whole aligned word.
      do_store("st_misaligned_word", 32'h22, 32'h01020304, M_W);
      do_load("ld_misaligned_word", 32'h20, M_W, 32'h01020304);

      repeat (5) @(posedge clk);
      #1;
      check32("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
